// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit : RV32I memory-stage load/store unit, single-outstanding bus.
// Revision: 1.0
// ============================================================================
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [2:0]  req_type,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        stall,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic [4:0]  resp_rd,
   output logic [1:0]  fault
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state, state_nxt;

   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [2:0]  r_type;
   logic        r_write;
   logic [4:0]  r_rd;
   logic [7:0]  r_count;

   logic        w_legal;
   logic        w_timeout;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_bshift;
   logic [31:0] w_hshift;
   logic [31:0] w_load;

   // Type codes 100/101 exist only as loads; stores above 010 are illegal.
   always_comb begin
      w_legal = 1'b0;
      case (req_type)
         3'b000:  w_legal = 1'b1;
         3'b001:  w_legal = ~req_addr[0];
         3'b010:  w_legal = (req_addr[1:0] == 2'b00);
         3'b100:  w_legal = ~req_write;
         3'b101:  w_legal = ~req_write & ~req_addr[0];
         default: w_legal = 1'b0;
      endcase
   end

   // Counter starts at 0 on BUS entry, so this is the TIMEOUT_CYCLES-th BUS cycle.
   assign w_timeout = (r_count == 8'(TIMEOUT_CYCLES - 1));

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = r_wdata;
      if (r_write) begin
         case (r_type[1:0])
            2'b00: begin
               w_be    = 4'b0001 << r_addr[1:0];
               w_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
               w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
               w_be    = 4'b1111;
               w_wdata = r_wdata;
            end
         endcase
      end
   end

   assign w_bshift = bus_rdata >> {r_addr[1:0], 3'b000};
   assign w_hshift = bus_rdata >> {r_addr[1], 4'b0000};

   always_comb begin
      case (r_type)
         3'b000:  w_load = {{24{w_bshift[7]}}, w_bshift[7:0]};
         3'b001:  w_load = {{16{w_hshift[15]}}, w_hshift[15:0]};
         3'b100:  w_load = {24'd0, w_bshift[7:0]};
         3'b101:  w_load = {16'd0, w_hshift[15:0]};
         default: w_load = bus_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      bus_req   = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = 32'd0;
      bus_wdata = 32'd0;
      bus_be    = 4'b0000;
      case (state)
         S_IDLE: begin
            if (req_valid && w_legal) begin
               stall     = 1'b1;
               state_nxt = S_BUS;
            end
         end
         S_BUS: begin
            stall     = 1'b1;
            bus_req   = 1'b1;
            bus_we    = r_write;
            bus_addr  = {r_addr[31:2], 2'b00};
            bus_wdata = w_wdata;
            bus_be    = w_be;
            if (bus_ack || w_timeout) state_nxt = S_RESP;
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         r_type     <= 3'd0;
         r_write    <= 1'b0;
         r_rd       <= 5'd0;
         r_count    <= 8'd0;
         resp_valid <= 1'b0;
         resp_data  <= 32'd0;
         resp_rd    <= 5'd0;
         fault      <= 2'b00;
      end else begin
         resp_valid <= 1'b0;
         resp_data  <= 32'd0;
         resp_rd    <= 5'd0;
         fault      <= 2'b00;
         case (state)
            S_IDLE: begin
               r_count <= 8'd0;
               if (req_valid) begin
                  if (w_legal) begin
                     r_addr  <= req_addr;
                     r_wdata <= req_wdata;
                     r_type  <= req_type;
                     r_write <= req_write;
                     r_rd    <= req_rd;
                  end else begin
                     fault <= 2'b01;
                  end
               end
            end
            S_BUS: begin
               // An ack on the final allowed cycle wins over the timeout.
               if (bus_ack) begin
                  resp_valid <= ~r_write;
                  resp_data  <= r_write ? 32'd0 : w_load;
                  resp_rd    <= r_write ? 5'd0 : r_rd;
               end else begin
                  r_count <= r_count + 8'd1;
                  if (w_timeout) begin
                     resp_valid <= ~r_write;
                     resp_rd    <= r_write ? 5'd0 : r_rd;
                     fault      <= 2'b10;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// tb_mem_access_unit : directed self-checking bench for mem_access_unit.
// Revision: 1.0
// ============================================================================
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_write;
   logic [2:0]  req_type;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        stall;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic [1:0]  fault;

   int checks = 0;
   int errors = 0;
   int n;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_write(req_write), .req_type(req_type),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .stall(stall),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_be(bus_be),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
      .fault(fault)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic wr, input logic [2:0] ty, input logic [31:0] ad,
                          input logic [31:0] wd, input logic [4:0] rd);
      req_valid = 1'b1;
      req_write = wr;
      req_type  = ty;
      req_addr  = ad;
      req_wdata = wd;
      req_rd    = rd;
   endtask

   // Full access with ack in the first BUS cycle; bench supplies all expectations.
   task automatic do_access(input string tag, input logic wr, input logic [2:0] ty,
                            input logic [31:0] ad, input logic [31:0] wd,
                            input logic [31:0] rdat, input logic [4:0] rd,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_data);
      set_req(wr, ty, ad, wd, rd);
      #1;
      chk({tag, " c0 stall"}, stall, 1);
      chk({tag, " c0 bus_req"}, bus_req, 0);
      tick();
      bus_ack   = 1'b1;
      bus_rdata = rdat;
      #1;
      chk({tag, " c1 bus_req"}, bus_req, 1);
      chk({tag, " c1 stall"}, stall, 1);
      chk({tag, " c1 bus_we"}, bus_we, wr);
      chk({tag, " c1 bus_addr"}, bus_addr, {ad[31:2], 2'b00});
      chk({tag, " c1 bus_be"}, bus_be, exp_be);
      if (wr) chk({tag, " c1 bus_wdata"}, bus_wdata, exp_wdata);
      tick();
      bus_ack   = 1'b0;
      req_valid = 1'b0;
      #1;
      chk({tag, " c2 stall"}, stall, 0);
      chk({tag, " c2 bus_req"}, bus_req, 0);
      chk({tag, " c2 resp_valid"}, resp_valid, !wr);
      chk({tag, " c2 fault"}, fault, 0);
      if (!wr) begin
         chk({tag, " c2 resp_data"}, resp_data, exp_data);
         chk({tag, " c2 resp_rd"}, resp_rd, rd);
      end
      tick();
      chk({tag, " c3 resp_valid"}, resp_valid, 0);
      chk({tag, " c3 resp_rd"}, resp_rd, 0);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_type  = 3'd0;
      req_addr  = 32'd0;
      req_wdata = 32'd0;
      req_rd    = 5'd0;
      bus_ack   = 1'b0;
      bus_rdata = 32'd0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("reset stall", stall, 0);
      chk("reset bus_req", bus_req, 0);
      chk("reset bus_be", bus_be, 0);
      chk("reset resp_valid", resp_valid, 0);
      chk("reset resp_data", resp_data, 0);
      chk("reset fault", fault, 0);

      // Loads: lane extraction and extension.
      do_access("LW 100", 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 5'd5, 4'b1111, 32'h0, 32'hDEADBEEF);
      do_access("LB 103", 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 5'd6, 4'b1111, 32'h0, 32'hFFFFFF80);
      do_access("LBU 103", 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 5'd7, 4'b1111, 32'h0, 32'h00000080);
      do_access("LB 101", 0, 3'b000, 32'h101, 32'h0, 32'h1234_7F00, 5'd8, 4'b1111, 32'h0, 32'h0000007F);
      do_access("LH 102", 0, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 5'd9, 4'b1111, 32'h0, 32'hFFFF8001);
      do_access("LHU 100", 0, 3'b101, 32'h100, 32'h0, 32'h8001_F234, 5'd10, 4'b1111, 32'h0, 32'h0000F234);

      // Stores: lane replication and byte enables.
      do_access("SH 102", 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 5'd0, 4'b1100, 32'hABCDABCD, 32'h0);
      do_access("SB 101", 1, 3'b000, 32'h101, 32'h00000077, 32'h0, 5'd0, 4'b0010, 32'h77777777, 32'h0);
      do_access("SW 204", 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 5'd0, 4'b1111, 32'hCAFEF00D, 32'h0);

      // Misaligned LW: no bus access, single fault[0] pulse.
      set_req(0, 3'b010, 32'h101, 32'h0, 5'd3);
      #1;
      chk("mis stall", stall, 0);
      tick();
      chk("mis bus_req", bus_req, 0);
      chk("mis fault", fault, 2'b01);
      chk("mis resp_valid", resp_valid, 0);
      req_valid = 1'b0;
      tick();
      chk("mis fault clear", fault, 0);

      // Illegal load type 011.
      set_req(0, 3'b011, 32'h100, 32'h0, 5'd3);
      #1;
      chk("ill stall", stall, 0);
      tick();
      chk("ill bus_req", bus_req, 0);
      chk("ill fault", fault, 2'b01);
      req_valid = 1'b0;
      tick();

      // Timeout: no ack for TIMEOUT_CYCLES=4 BUS cycles.
      set_req(0, 3'b010, 32'h200, 32'h0, 5'd11);
      #1;
      tick();
      n = 0;
      for (int i = 0; i < 20 && bus_req; i++) begin
         n++;
         tick();
      end
      chk("tmo bus_req cycles", n, 4);
      chk("tmo fault", fault, 2'b10);
      chk("tmo resp_data", resp_data, 0);
      req_valid = 1'b0;
      tick();
      chk("tmo fault clear", fault, 0);
      chk("tmo stall", stall, 0);
      chk("tmo bus_req", bus_req, 0);

      // Ack on the same cycle the counter would expire: success.
      set_req(0, 3'b010, 32'h208, 32'h0, 5'd12);
      #1;
      tick();
      tick();
      tick();
      tick();
      bus_ack   = 1'b1;
      bus_rdata = 32'h12345678;
      #1;
      chk("edge c4 bus_req", bus_req, 1);
      tick();
      bus_ack   = 1'b0;
      req_valid = 1'b0;
      #1;
      chk("edge fault", fault, 0);
      chk("edge resp_valid", resp_valid, 1);
      chk("edge resp_data", resp_data, 32'h12345678);
      tick();

      // Reset in the second BUS cycle abandons the access.
      set_req(0, 3'b010, 32'h300, 32'h0, 5'd13);
      #1;
      tick();
      tick();
      chk("rst c2 bus_req", bus_req, 1);
      rst       = 1'b1;
      req_valid = 1'b0;
      tick();
      chk("rst bus_req", bus_req, 0);
      chk("rst stall", stall, 0);
      chk("rst resp_valid", resp_valid, 0);
      chk("rst fault", fault, 0);
      rst = 1'b0;
      tick();
      do_access("LW after rst", 0, 3'b010, 32'h304, 32'h0, 32'hAABBCCDD, 5'd14, 4'b1111, 32'h0, 32'hAABBCCDD);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
